// File: rtl/lcd_nibble_tx_if.sv
// Upstream transfer handshake for lcd_nibble_tx: one command/data byte (or
// a lone high nibble during 8-bit-mode init) per accepted valid/ready beat.
interface lcd_nibble_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_nibble;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        output in_nibble,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        input  in_nibble,
        output in_ready
    );
endinterface

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit bus transmitter: sends a latched byte as two E-strobed
// nibbles (or a single nibble), then waits out the controller execution time.
module lcd_nibble_tx #(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 4,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 50,
    parameter int LONG_CYC  = 2000,
    parameter int POR_CYC   = 3000
) (
    input  logic           clk,
    input  logic           rst_n,
    lcd_nibble_tx_if.slave up,
    output logic           busy,
    output logic           rs,
    output logic           e,
    output logic [3:0]     d
);
    typedef enum logic [3:0] {
        ST_POR   = 4'd0,
        ST_IDLE  = 4'd1,
        ST_SET_H = 4'd2,
        ST_EN_H  = 4'd3,
        ST_HLD_H = 4'd4,
        ST_SET_L = 4'd5,
        ST_EN_L  = 4'd6,
        ST_HLD_L = 4'd7,
        ST_WAIT  = 4'd8
    } state_t;

    // All phase lengths must fit the shared 16-bit counter (1..65535).
    localparam logic [15:0] SETUP_L = 16'(SETUP_CYC);
    localparam logic [15:0] E_L     = 16'(E_CYC);
    localparam logic [15:0] HOLD_L  = 16'(HOLD_CYC);
    localparam logic [15:0] GAP_L   = 16'(GAP_CYC);
    localparam logic [15:0] LONG_L  = 16'(LONG_CYC);
    localparam logic [15:0] POR_L   = 16'(POR_CYC);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        nib_q, nib_d;
    logic        rs_q, rs_d;
    logic [3:0]  d_q, d_d;
    logic        e_q, e_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        last_s;
    logic [15:0] wait_len_s;

    assign last_s     = (cnt_q == 16'd1);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign wait_len_s = (!rs_q && !nib_q && (data_q <= 8'h03)) ? LONG_L : GAP_L;

    // Next-state, phase counter and output register inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        data_d  = data_q;
        nib_d   = nib_q;
        rs_d    = rs_q;
        d_d     = d_q;
        case (state_q)
            ST_POR: begin
                if (last_s) state_d = ST_IDLE;
                else        state_d = ST_POR;
            end
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (up.in_valid) begin
                    state_d = ST_SET_H;
                    cnt_d   = SETUP_L;
                    data_d  = up.in_data;
                    nib_d   = up.in_nibble;
                    rs_d    = up.in_rs;
                    d_d     = up.in_data[7:4];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET_H: begin
                if (last_s) begin
                    state_d = ST_EN_H;
                    cnt_d   = E_L;
                end else begin
                    state_d = ST_SET_H;
                end
            end
            ST_EN_H: begin
                if (last_s) begin
                    state_d = ST_HLD_H;
                    cnt_d   = HOLD_L;
                end else begin
                    state_d = ST_EN_H;
                end
            end
            ST_HLD_H: begin
                if (last_s && nib_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_len_s;
                end else if (last_s) begin
                    state_d = ST_SET_L;
                    cnt_d   = SETUP_L;
                    d_d     = data_q[3:0];
                end else begin
                    state_d = ST_HLD_H;
                end
            end
            ST_SET_L: begin
                if (last_s) begin
                    state_d = ST_EN_L;
                    cnt_d   = E_L;
                end else begin
                    state_d = ST_SET_L;
                end
            end
            ST_EN_L: begin
                if (last_s) begin
                    state_d = ST_HLD_L;
                    cnt_d   = HOLD_L;
                end else begin
                    state_d = ST_EN_L;
                end
            end
            ST_HLD_L: begin
                if (last_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_len_s;
                end else begin
                    state_d = ST_HLD_L;
                end
            end
            ST_WAIT: begin
                if (last_s) state_d = ST_IDLE;
                else        state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = POR_L;
            end
        endcase
        e_d     = (state_d == ST_EN_H) || (state_d == ST_EN_L);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counter, latched transfer and pin registers; reset kills any E pulse at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_POR;
            cnt_q   <= POR_L;
            data_q  <= 8'h00;
            nib_q   <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= 4'h0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            nib_q   <= nib_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign up.in_ready = ready_q;
    assign busy        = busy_q;
    assign rs          = rs_q;
    assign e           = e_q;
    assign d           = d_q;
endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Bench for lcd_nibble_tx: directed vector table, back-to-back and reset
// sequences, plus random traffic checked every cycle against a timing model.
module tb_lcd_nibble_tx;
    localparam int S    = 2;
    localparam int EC   = 4;
    localparam int H    = 2;
    localparam int GAP  = 50;
    localparam int LONG = 2000;
    localparam int POR  = 3000;
    localparam int P    = S + EC + H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, rs, e;
    logic [3:0] d;
    int         errors = 0;
    int         checks = 0;

    lcd_nibble_tx_if bus ();

    lcd_nibble_tx #(
        .SETUP_CYC(S), .E_CYC(EC), .HOLD_CYC(H),
        .GAP_CYC(GAP), .LONG_CYC(LONG), .POR_CYC(POR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .up(bus.slave),
        .busy(busy), .rs(rs), .e(e), .d(d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: derives pin values from the cycle index inside a transfer.
    int         m_por, m_k;
    bit         m_act;
    logic       m_trs, m_tnib, m_rs, m_rdy, m_e;
    logic [7:0] m_tdata;
    logic [3:0] m_d;

    initial begin
        int n, total, wt, off;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_por = POR; m_act = 1'b0; m_rs = 1'b0; m_d = 4'h0;
                check("reset_pins", int'({bus.in_ready, busy, e, rs, d}), int'(8'b0100_0000));
            end else begin
                m_rdy = 1'b0; m_e = 1'b0;
                if (m_por > 0) begin
                    m_por--;
                end else if (m_act) begin
                    n     = m_tnib ? 1 : 2;
                    wt    = (!m_trs && !m_tnib && m_tdata <= 8'h03) ? LONG : GAP;
                    total = 1 + n * P + wt;
                    if (m_k <= n * P) begin
                        off  = (m_k - 1) % P;
                        m_e  = (off >= S) && (off < S + EC);
                        m_rs = m_trs;
                        m_d  = ((m_k - 1) / P == 0) ? m_tdata[7:4] : m_tdata[3:0];
                    end
                    if (m_k == total) begin
                        m_act = 1'b0; m_rdy = 1'b1;
                    end else begin
                        m_k++;
                    end
                end else begin
                    m_rdy = 1'b1;
                end
                check("cycle_pins", int'({bus.in_ready, busy, e, rs, d}),
                      int'({m_rdy, ~m_rdy, m_e, m_rs, m_d}));
                if (m_rdy && bus.in_valid) begin
                    m_act = 1'b1; m_k = 1;
                    m_trs = bus.in_rs; m_tdata = bus.in_data; m_tnib = bus.in_nibble;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        @(posedge clk); #1;
        for (int i = 0; i < 5000; i++) begin
            if (bus.in_ready) break;
            @(posedge clk); #1;
        end
        if (!bus.in_ready) check("ready_wait", 0, 1);
    endtask

    // Counts negedges from release until ready, and E pulses seen meanwhile.
    task automatic measure_por(output int rdy_cyc, output int pulses);
        logic prev_e = 1'b0;
        rdy_cyc = -1; pulses = 0;
        for (int k = 1; k <= 3500; k++) begin
            @(negedge clk);
            if (e && !prev_e) pulses++;
            prev_e = e;
            if (bus.in_ready) begin rdy_cyc = k; break; end
        end
    endtask

    task automatic send(input logic rs_i, input logic [7:0] data_i, input logic nib_i,
                        output int rdy_cyc, output int pulses, output int first_e,
                        output int e_cyc, output logic [3:0] d1, output logic [3:0] d2,
                        output logic rs_e);
        logic prev_e = 1'b0;
        rdy_cyc = -1; pulses = 0; first_e = -1; e_cyc = 0; d1 = 4'h0; d2 = 4'h0; rs_e = 1'b0;
        wait_ready();
        bus.in_valid = 1'b1; bus.in_rs = rs_i; bus.in_data = data_i; bus.in_nibble = nib_i;
        for (int k = 1; k <= 2100; k++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.in_data   = 8'($urandom);
            bus.in_rs     = 1'($urandom);
            bus.in_nibble = 1'($urandom);
            @(negedge clk);
            if (e) begin
                e_cyc++;
                if (!prev_e) begin
                    pulses++;
                    if (pulses == 1) begin first_e = k; d1 = d; rs_e = rs; end
                    else d2 = d;
                end
            end
            prev_e = e;
            if (bus.in_ready) begin rdy_cyc = k; break; end
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       nib;
        int         rdy_cyc;
        int         pulses;
        logic [3:0] d1;
        logic [3:0] d2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int rc, pc, fe, ec, rise_n;
        logic [3:0] d1, d2;
        logic rse, prev_e;
        int rise_k[8];
        logic [3:0] rise_d[8];

        vecs[0] = '{1'b1, 8'h48, 1'b0, 67,   2, 4'h4, 4'h8};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 2017, 2, 4'h0, 4'h1};
        vecs[2] = '{1'b0, 8'h30, 1'b1, 59,   1, 4'h3, 4'h0};
        vecs[3] = '{1'b0, 8'h03, 1'b0, 2017, 2, 4'h0, 4'h3};
        vecs[4] = '{1'b0, 8'h04, 1'b0, 67,   2, 4'h0, 4'h4};
        vecs[5] = '{1'b1, 8'h02, 1'b0, 67,   2, 4'h0, 4'h2};
        vecs[6] = '{1'b0, 8'h02, 1'b1, 59,   1, 4'h0, 4'h0};

        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h48; bus.in_nibble = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        measure_por(rc, pc);
        check("por_ready_cycle", rc, POR + 1);
        check("por_e_pulses", pc, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].rs, vecs[i].data, vecs[i].nib, rc, pc, fe, ec, d1, d2, rse);
            check($sformatf("vec%0d_ready_cycle", i), rc, vecs[i].rdy_cyc);
            check($sformatf("vec%0d_pulses", i), pc, vecs[i].pulses);
            check($sformatf("vec%0d_first_e", i), fe, 3);
            check($sformatf("vec%0d_e_cycles", i), ec, 4 * vecs[i].pulses);
            check($sformatf("vec%0d_d_hi", i), int'(d1), int'(vecs[i].d1));
            check($sformatf("vec%0d_rs", i), int'(rse), int'(vecs[i].rs));
            if (vecs[i].pulses == 2) check($sformatf("vec%0d_d_lo", i), int'(d2), int'(vecs[i].d2));
        end

        // Back-to-back: valid held high, inputs changed mid-transfer.
        wait_ready();
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'hA5; bus.in_nibble = 1'b0;
        rise_n = 0; prev_e = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.in_data = 8'h3C;
            if (k == 68) bus.in_valid = 1'b0;
            @(negedge clk);
            if (e && !prev_e && rise_n < 8) begin
                rise_k[rise_n] = k; rise_d[rise_n] = d; rise_n++;
            end
            prev_e = e;
            if (k == 67)  check("b2b_ready_at_67", int'(bus.in_ready), 1);
            if (k == 68)  check("b2b_busy_at_68", int'(bus.in_ready), 0);
            if (k == 134) check("b2b_ready_at_134", int'(bus.in_ready), 1);
        end
        check("b2b_rises", rise_n, 4);
        if (rise_n == 4) begin
            check("b2b_rise0", rise_k[0], 3);  check("b2b_d0", int'(rise_d[0]), 'hA);
            check("b2b_rise1", rise_k[1], 11); check("b2b_d1", int'(rise_d[1]), 'h5);
            check("b2b_rise2", rise_k[2], 70); check("b2b_d2", int'(rise_d[2]), 'h3);
            check("b2b_rise3", rise_k[3], 78); check("b2b_d3", int'(rise_d[3]), 'hC);
        end

        // Reset while E is high: E must drop asynchronously, then a full POR repeats.
        wait_ready();
        bus.in_valid = 1'b1; bus.in_rs = 1'b1; bus.in_data = 8'h48; bus.in_nibble = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("mid_e_high", int'(e), 1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_pins", int'({bus.in_ready, busy, e, rs, d}), int'(8'b0100_0000));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        measure_por(rc, pc);
        check("rst_por_ready_cycle", rc, POR + 1);
        check("rst_por_e_pulses", pc, 0);

        // Random traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_rs     = 1'($urandom);
            bus.in_nibble = ($urandom_range(0, 3) == 0);
            bus.in_data   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        end
        bus.in_valid = 1'b0;
        wait_ready();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
